// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-and-add-3), one bit
//            per clock. Feeds per-digit seven-segment decoders.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-high reset
//            start    - conversion request, sampled only while ready=1
//            bin_in   - unsigned binary input, captured on the accepting edge
//            ready    - high while idle, a start will be accepted
//            done     - one-cycle pulse, bcd_out/overflow newly updated
//            bcd_out  - packed BCD, digit k = bcd_out[4k+3:4k], digit 0 = units
//            overflow - value did not fit in DIGITS digits, held until next done
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int c_bcd_w = 4 * DIGITS;
    localparam int c_cat_w = c_bcd_w + WIDTH;
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic                 r_ovf_acc;
    logic [c_cnt_w-1:0]   r_count;

    logic [c_bcd_w-1:0]   w_adj;
    logic [c_cat_w-1:0]   w_cat;
    logic [c_cat_w-1:0]   w_cat_sh;
    logic                 w_carry;

    // Digit-local add-3: a digit of 5..9 becomes 8..12, so no carry ever
    // crosses into the neighbouring digit.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ?
                                     (r_bcd[4*k +: 4] + 4'd3) :
                                     r_bcd[4*k +: 4];
        end
    endgenerate

    // One double-dabble step on {adjusted BCD, binary}. The bit leaving the
    // top digit is only meaningful as an overflow indication.
    assign w_cat    = {w_adj, r_bin};
    assign w_cat_sh = {w_cat[c_cat_w-2:0], 1'b0};
    assign w_carry  = w_cat[c_cat_w-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_ovf_acc <= 1'b0;
            r_count   <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_bin     <= bin_in;
                        r_bcd     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_count   <= '0;
                        ready     <= 1'b0;
                        r_state   <= S_SHIFT;
                    end else begin
                        ready     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_bcd     <= w_cat_sh[c_cat_w-1:WIDTH];
                    r_bin     <= w_cat_sh[WIDTH-1:0];
                    r_ovf_acc <= r_ovf_acc | w_carry;
                    r_count   <= r_count + c_one;
                    ready     <= 1'b0;
                    // Final iteration: publish the post-shift result directly
                    // so outputs only ever move on this edge.
                    if (r_count == c_last) begin
                        bcd_out  <= w_cat_sh[c_cat_w-1:WIDTH];
                        overflow <= r_ovf_acc | w_carry;
                        done     <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
